// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader.
//   state_e   : loader FSM states
//   HDR_BYTES : number of length-header bytes preceding the program words
//   LEN_W     : width of the word-count header / word index
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_LO,
    ST_LEN_HI,
    ST_DATA,
    ST_WRITE,
    ST_DONE,
    ST_ERR
  } state_e;

  localparam int unsigned HDR_BYTES = 2;
  localparam int unsigned LEN_W     = HDR_BYTES * 8;

endpackage

// File: rtl/imem_word_assembler.sv
// Byte-to-word assembler: collects four bytes, least-significant first.
//   clk, rst    : clock, synchronous active-high reset
//   clr         : clears the byte counter and shift register
//   byte_valid  : byte_in is consumed this cycle
//   byte_in     : incoming byte
//   word_o      : assembled word including the byte currently presented
//   last_o      : the byte consumed this cycle completes a word
module imem_word_assembler #(
  parameter int unsigned width = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             byte_valid,
  input  logic [7:0]       byte_in,
  output logic [width-1:0] word_o,
  output logic             last_o
);

  logic [width-1:0] shift_q, shift_d;
  logic [1:0]       cnt_q, cnt_d;

  // Right shift: after four bytes, byte k sits in bits [8k+7:8k]. word_o
  // already merges the current byte so the caller can capture the full
  // word on the same edge that accepts the fourth byte.
  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    word_o  = {byte_in, shift_q[width-1:8]};
    last_o  = byte_valid && (cnt_q == 2'd3);
    if (clr) begin
      shift_d = '0;
      cnt_d   = '0;
    end else if (byte_valid) begin
      shift_d = word_o;
      cnt_d   = cnt_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: receives a byte stream (16-bit word count N,
// low byte first, then N little-endian 32-bit words) and writes each word
// into instruction memory, holding the core in reset until the load is done.
//   clk, rst          : clock, synchronous active-high reset
//   start             : pulse that begins (or restarts) a load
//   rx_data/rx_valid  : incoming byte stream
//   rx_ready          : loader accepts a byte this cycle
//   WE/WA/WD          : instruction-memory write port (WA byte address)
//   cpu_rst           : core reset, released only after a successful load
//   done/error        : load finished / length header rejected
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned width       = 32,
  parameter int unsigned Address_Bus = 32,
  parameter int unsigned DEPTH       = 256
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  output logic                   rx_ready,
  output logic                   WE,
  output logic [Address_Bus-1:0] WA,
  output logic [width-1:0]       WD,
  output logic                   cpu_rst,
  output logic                   done,
  output logic                   error
);

  localparam logic [LEN_W:0] DEPTH_W = (LEN_W + 1)'(DEPTH);

  state_e                 state_q, state_d;
  logic [LEN_W-1:0]       len_q, len_d;
  logic [LEN_W-1:0]       idx_q, idx_d;
  logic                   rx_ready_q, rx_ready_d;
  logic                   we_q, we_d;
  logic [Address_Bus-1:0] wa_q, wa_d;
  logic [width-1:0]       wd_q, wd_d;
  logic                   cpu_rst_q, cpu_rst_d;
  logic                   done_q, done_d;
  logic                   error_q, error_d;

  logic                   accept;
  logic                   asm_valid;
  logic                   asm_clr;
  logic                   asm_last;
  logic [width-1:0]       asm_word;
  logic [LEN_W-1:0]       len_full;
  logic [LEN_W-1:0]       idx_inc;

  assign accept   = rx_valid && rx_ready_q;
  assign len_full = {rx_data, len_q[7:0]};
  assign idx_inc  = idx_q + 1'b1;

  imem_word_assembler #(
    .width(width)
  ) u_asm (
    .clk       (clk),
    .rst       (rst),
    .clr       (asm_clr),
    .byte_valid(asm_valid),
    .byte_in   (rx_data),
    .word_o    (asm_word),
    .last_o    (asm_last)
  );

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    idx_d     = idx_q;
    wa_d      = wa_q;
    wd_d      = wd_q;
    asm_clr   = 1'b0;
    asm_valid = accept && (state_q == ST_DATA);

    case (state_q)
      ST_IDLE: if (start) state_d = ST_LEN_LO;
      ST_LEN_LO: begin
        if (accept) begin
          len_d[7:0] = rx_data;
          state_d    = ST_LEN_HI;
        end
      end
      ST_LEN_HI: begin
        if (accept) begin
          len_d = len_full;
          if (len_full == '0 || {1'b0, len_full} > DEPTH_W) begin
            state_d = ST_ERR;
          end else begin
            state_d = ST_DATA;
            idx_d   = '0;
            asm_clr = 1'b1;
          end
        end
      end
      ST_DATA: begin
        // Capture address and word on the fourth byte so WE rises next cycle.
        if (asm_last) begin
          state_d = ST_WRITE;
          wa_d    = Address_Bus'({idx_q, 2'b00});
          wd_d    = asm_word;
        end
      end
      ST_WRITE: begin
        idx_d   = idx_inc;
        state_d = (idx_inc == len_q) ? ST_DONE : ST_DATA;
      end
      ST_DONE, ST_ERR: if (start) state_d = ST_LEN_LO;
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered from the next state so they line up with it.
    rx_ready_d = state_d inside {ST_LEN_LO, ST_LEN_HI, ST_DATA};
    we_d       = (state_d == ST_WRITE);
    cpu_rst_d  = (state_d != ST_DONE);
    done_d     = (state_d == ST_DONE);
    error_d    = (state_d == ST_ERR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      idx_q      <= '0;
      rx_ready_q <= 1'b0;
      we_q       <= 1'b0;
      wa_q       <= '0;
      wd_q       <= '0;
      cpu_rst_q  <= 1'b1;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      rx_ready_q <= rx_ready_d;
      we_q       <= we_d;
      wa_q       <= wa_d;
      wd_q       <= wd_d;
      cpu_rst_q  <= cpu_rst_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  assign rx_ready = rx_ready_q;
  assign WE       = we_q;
  assign WA       = wa_q;
  assign WD       = wd_q;
  assign cpu_rst  = cpu_rst_q;
  assign done     = done_q;
  assign error    = error_q;

endmodule
